// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizes for the I/D-cache memory port arbiter.
// Also holds the grant priority function.
package mem_port_arbiter_pkg;

  localparam int unsigned WordSize  = 16;
  localparam int unsigned FetchSize = 64;
  localparam int unsigned CntWidth  = 16;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbBusy = 2'd1,
    ArbDone = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerI = 1'b0,
    OwnerD = 1'b1
  } owner_e;

  // Lock reserves the port for D; otherwise a lone requester wins and a tie goes to the
  // requester that did not own the previous access.
  function automatic owner_e pick_owner(input logic   lock,
                                        input logic   i_req,
                                        input logic   d_req,
                                        input owner_e last_owner);
    owner_e owner;
    if (lock && d_req) begin
      owner = OwnerD;
    end else if (i_req && !d_req) begin
      owner = OwnerI;
    end else if (d_req && !i_req) begin
      owner = OwnerD;
    end else begin
      owner = (last_owner == OwnerI) ? OwnerD : OwnerI;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side request/grant signals and memory-side strobes of the shared port.
// slave is the arbiter's view; master is the view of the caches plus memory model.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic                 i_req;
  logic [WordSize-1:0]  i_addr;
  logic                 i_grant;
  logic                 i_done;

  logic                 d_req;
  logic                 d_write;
  logic                 d_lock;
  logic [WordSize-1:0]  d_addr;
  logic [FetchSize-1:0] d_wdata;
  logic                 d_grant;
  logic                 d_done;

  logic [FetchSize-1:0] rdata;
  logic                 readM;
  logic                 writeM;
  logic [WordSize-1:0]  addressM;
  logic [FetchSize-1:0] m_wdata;
  logic [FetchSize-1:0] m_rdata;

  logic [CntWidth-1:0]  i_grantCnt;
  logic [CntWidth-1:0]  d_grantCnt;
  logic [CntWidth-1:0]  conflictCnt;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_lock, d_addr, d_wdata, m_rdata,
    output i_grant, i_done, d_grant, d_done, rdata, readM, writeM, addressM, m_wdata,
           i_grantCnt, d_grantCnt, conflictCnt
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_lock, d_addr, d_wdata, m_rdata,
    input  i_grant, i_done, d_grant, d_done, rdata, readM, writeM, addressM, m_wdata,
           i_grantCnt, d_grantCnt, conflictCnt
  );

endinterface

// File: rtl/mem_port_arbiter_stats.sv
// Grant and contention statistics for the memory port arbiter.
// Grant counters wrap; the conflict counter saturates.
module mem_port_arbiter_stats
  import mem_port_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_i_inc,
  input  logic                i_d_inc,
  input  logic                i_conflict,
  output logic [CntWidth-1:0] o_i_cnt,
  output logic [CntWidth-1:0] o_d_cnt,
  output logic [CntWidth-1:0] o_conflict_cnt
);

  logic [CntWidth-1:0] r_i_cnt;
  logic [CntWidth-1:0] r_d_cnt;
  logic [CntWidth-1:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i_cnt        <= '0;
      r_d_cnt        <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (i_i_inc) begin
        r_i_cnt <= r_i_cnt + CntWidth'(1);
      end
      if (i_d_inc) begin
        r_d_cnt <= r_d_cnt + CntWidth'(1);
      end
      if (i_conflict && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CntWidth'(1);
      end
    end
  end

  assign o_i_cnt        = r_i_cnt;
  assign o_d_cnt        = r_d_cnt;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache miss engines,
// sequencing a fixed-latency access per grant: IDLE -> BUSY -> DONE -> IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned     LatW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LatW-1:0] LatLoad = LatW'(MEM_LATENCY - 1);

  arb_state_e           r_state;
  arb_state_e           w_state_next;
  owner_e               r_owner;
  owner_e               r_last_owner;
  owner_e               w_pick;
  logic                 r_dir;
  logic                 r_lock;
  logic                 r_lock_smp;
  logic [LatW-1:0]      r_cnt;
  logic [WordSize-1:0]  r_addr;
  logic [FetchSize-1:0] r_wdata;
  logic [FetchSize-1:0] r_rdata;

  logic                 w_take;
  logic                 w_capture;
  logic                 w_finish;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_pick_d;
  logic                 w_conflict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ArbIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_capture    = 1'b0;
    w_finish     = 1'b0;
    w_pick       = pick_owner(r_lock, bus.i_req, bus.d_req, r_last_owner);
    unique case (r_state)
      ArbIdle: begin
        if (bus.i_req || bus.d_req) begin
          w_take       = 1'b1;
          w_state_next = ArbBusy;
        end
      end
      ArbBusy: begin
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_state_next = ArbDone;
        end
      end
      ArbDone: begin
        w_finish     = 1'b1;
        w_state_next = ArbIdle;
      end
      default: w_state_next = ArbIdle;
    endcase
  end

  assign w_pick_d = (w_pick == OwnerD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OwnerI;
      r_last_owner <= OwnerI;
      r_dir        <= 1'b0;
      r_lock       <= 1'b0;
      r_lock_smp   <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      // I-cache requests are always line fills, so only D can set the write direction.
      if (w_take) begin
        r_owner    <= w_pick;
        r_dir      <= w_pick_d && bus.d_write;
        r_addr     <= w_pick_d ? bus.d_addr : bus.i_addr;
        r_wdata    <= (w_pick_d && bus.d_write) ? bus.d_wdata : '0;
        r_lock_smp <= w_pick_d && bus.d_lock;
        r_cnt      <= LatLoad;
      end else if ((r_state == ArbBusy) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - LatW'(1);
      end

      if (w_capture) begin
        r_rdata <= r_dir ? '0 : bus.m_rdata;
      end

      // A reservation whose requester has gone away is dropped rather than stalling I.
      if (w_finish) begin
        r_last_owner <= r_owner;
        if (r_owner == OwnerD) begin
          r_lock <= r_lock_smp;
        end
      end else if ((r_state == ArbIdle) && r_lock && !bus.d_req) begin
        r_lock <= 1'b0;
      end
    end
  end

  assign w_busy     = (r_state == ArbBusy);
  assign w_done     = (r_state == ArbDone);
  assign w_conflict = (r_state == ArbIdle) && bus.i_req && bus.d_req;

  assign bus.i_grant  = (w_busy || w_done) && (r_owner == OwnerI);
  assign bus.d_grant  = (w_busy || w_done) && (r_owner == OwnerD);
  assign bus.i_done   = w_done && (r_owner == OwnerI);
  assign bus.d_done   = w_done && (r_owner == OwnerD);
  assign bus.readM    = w_busy && !r_dir;
  assign bus.writeM   = w_busy && r_dir;
  assign bus.addressM = r_addr;
  assign bus.m_wdata  = (w_busy && r_dir) ? r_wdata : '0;
  assign bus.rdata    = w_done ? r_rdata : '0;

  mem_port_arbiter_stats u_stats (
    .clk            (clk),
    .reset          (reset),
    .i_i_inc        (w_finish && (r_owner == OwnerI)),
    .i_d_inc        (w_finish && (r_owner == OwnerD)),
    .i_conflict     (w_conflict),
    .o_i_cnt        (bus.i_grantCnt),
    .o_d_cnt        (bus.d_grantCnt),
    .o_conflict_cnt (bus.conflictCnt)
  );

  a_strobe_excl : assert property (@(posedge clk) disable iff (reset)
                                   !(bus.readM && bus.writeM));
  a_grant_excl  : assert property (@(posedge clk) disable iff (reset)
                                   !(bus.i_grant && bus.d_grant));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected completions are queued in arbitration
// order as requests are issued and checked against each done pulse.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned Lat = 4;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic        lock;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic        owner;
    logic [15:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.MEM_LATENCY(Lat)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  req_t        i_q[$];
  req_t        d_q[$];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          strobe_cnt = 0;
  int          grant_cyc = 0;
  logic [15:0] seen_addr;
  logic        seen_wr;
  logic [63:0] seen_wdata;

  function automatic logic [63:0] mem_line(input logic [15:0] a);
    return {a, 16'hC0DE, ~a, a ^ 16'h5A5A};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    bus_a.i_req = (i_q.size() != 0);
    bus_a.i_addr = (i_q.size() != 0) ? i_q[0].addr : 16'h0;
    bus_a.d_req = (d_q.size() != 0);
    if (d_q.size() != 0) begin
      bus_a.d_addr  = d_q[0].addr;
      bus_a.d_write = d_q[0].wr;
      bus_a.d_lock  = d_q[0].lock;
      bus_a.d_wdata = d_q[0].wdata;
    end else begin
      bus_a.d_addr  = 16'h0;
      bus_a.d_write = 1'b0;
      bus_a.d_lock  = 1'b0;
      bus_a.d_wdata = 64'h0;
    end
  endtask

  task automatic push_i(input logic [15:0] addr);
    req_t r;
    r.addr = addr; r.wr = 1'b0; r.lock = 1'b0; r.wdata = 64'h0;
    i_q.push_back(r);
    drive_reqs();
  endtask

  task automatic push_d(input logic [15:0] addr, input logic wr, input logic lock,
                        input logic [63:0] wdata);
    req_t r;
    r.addr = addr; r.wr = wr; r.lock = lock; r.wdata = wdata;
    d_q.push_back(r);
    drive_reqs();
  endtask

  task automatic expect_acc(input logic owner, input logic [15:0] addr, input logic wr,
                            input logic [63:0] wdata);
    exp_t e;
    e.owner = owner; e.addr = addr; e.wr = wr;
    e.wdata = wr ? wdata : 64'h0;
    e.rdata = wr ? 64'h0 : mem_line(addr);
    exp_q.push_back(e);
  endtask

  // One clock of bus-side activity on DUT A: memory model, done scoreboard, request drive.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    check_eq("exclusive", 64'({bus_a.readM && bus_a.writeM, bus_a.i_grant && bus_a.d_grant,
                               bus_a.i_done && bus_a.d_done}), 64'h0);
    bus_a.m_rdata = 64'hFFFF_0BAD_FFFF_0BAD;
    if (reset) begin
      strobe_cnt = 0;
      grant_cyc  = 0;
    end else begin
      if (bus_a.i_grant || bus_a.d_grant) grant_cyc++;
      if (bus_a.readM || bus_a.writeM) begin
        strobe_cnt++;
        if (strobe_cnt == 1) begin
          seen_addr  = bus_a.addressM;
          seen_wr    = bus_a.writeM;
          seen_wdata = bus_a.m_wdata;
        end
        if (bus_a.readM && (strobe_cnt == Lat)) bus_a.m_rdata = mem_line(bus_a.addressM);
      end
      if (bus_a.i_done || bus_a.d_done) begin
        check_eq("exp_pending", 64'(exp_q.size() != 0), 64'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("owner", 64'(bus_a.d_done), 64'(e.owner));
          check_eq("addressM", 64'(seen_addr), 64'(e.addr));
          check_eq("dir", 64'(seen_wr), 64'(e.wr));
          check_eq("m_wdata", seen_wdata, e.wdata);
          check_eq("rdata", bus_a.rdata, e.rdata);
          check_eq("strobe_cycles", 64'(strobe_cnt), 64'(Lat));
          check_eq("grant_to_done", 64'(grant_cyc), 64'(Lat + 1));
        end
        strobe_cnt = 0;
        grant_cyc  = 0;
        if (bus_a.i_done && (i_q.size() != 0)) i_q.delete(0);
        if (bus_a.d_done && (d_q.size() != 0)) d_q.delete(0);
      end
    end
    drive_reqs();
  endtask

  task automatic drain(input int max_cyc);
    logic busy;
    busy = 1'b1;
    for (int n = 0; (n < max_cyc) && busy; n++) begin
      tick();
      busy = (i_q.size() != 0) || (d_q.size() != 0) || (exp_q.size() != 0) ||
             bus_a.i_grant || bus_a.d_grant;
    end
    check_eq("drain", 64'(busy), 64'h0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctl"}, 64'({bus_a.i_grant, bus_a.d_grant, bus_a.i_done, bus_a.d_done,
                                 bus_a.readM, bus_a.writeM}), 64'h0);
    check_eq({tag, "_addressM"}, 64'(bus_a.addressM), 64'h0);
    check_eq({tag, "_rdata"}, bus_a.rdata, 64'h0);
    check_eq({tag, "_m_wdata"}, bus_a.m_wdata, 64'h0);
    check_eq({tag, "_cnts"}, 64'({bus_a.i_grantCnt, bus_a.d_grantCnt, bus_a.conflictCnt}),
             64'h0);
  endtask

  task automatic check_cnts(input string tag, input int ic, input int dc, input int cc);
    check_eq({tag, "_i_grantCnt"}, 64'(bus_a.i_grantCnt), 64'(ic));
    check_eq({tag, "_d_grantCnt"}, 64'(bus_a.d_grantCnt), 64'(dc));
    check_eq({tag, "_conflictCnt"}, 64'(bus_a.conflictCnt), 64'(cc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1;
    bus_a.m_rdata = 64'h0;
    bus_b.i_req = 1'b0; bus_b.i_addr = 16'h0; bus_b.d_req = 1'b0; bus_b.d_write = 1'b0;
    bus_b.d_lock = 1'b0; bus_b.d_addr = 16'h0; bus_b.d_wdata = 64'h0;
    bus_b.m_rdata = mem_line(16'h0500);
    drive_reqs();
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b0;

    // Lone I fill
    push_i(16'h0040);
    expect_acc(1'b0, 16'h0040, 1'b0, 64'h0);
    drain(100);
    check_cnts("lone_i", 1, 0, 0);

    // Reset clears counters and last owner; simultaneous requests then go to D first
    reset = 1'b1;
    repeat (2) tick();
    check_idle("reset2");
    reset = 1'b0;
    push_d(16'h0200, 1'b0, 1'b0, 64'h0);
    push_i(16'h0300);
    expect_acc(1'b1, 16'h0200, 1'b0, 64'h0);
    expect_acc(1'b0, 16'h0300, 1'b0, 64'h0);
    drain(100);
    check_cnts("tie", 1, 1, 1);

    // Locked write-back keeps the port for the D refill ahead of a waiting I request
    push_d(16'h0080, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    expect_acc(1'b1, 16'h0080, 1'b1, 64'hDEAD_BEEF_0123_4567);
    repeat (2) tick();
    push_d(16'h0080, 1'b0, 1'b0, 64'h0);
    push_i(16'h0100);
    expect_acc(1'b1, 16'h0080, 1'b0, 64'h0);
    expect_acc(1'b0, 16'h0100, 1'b0, 64'h0);
    drain(100);
    check_cnts("lock", 2, 3, 2);

    // Sustained contention alternates, starting with D since I owned the last access
    for (int k = 0; k < 3; k++) begin
      push_i(16'h1000 + 16'(k * 16));
      push_d(16'h2000 + 16'(k * 16), 1'b0, 1'b0, 64'h0);
    end
    for (int k = 0; k < 3; k++) begin
      expect_acc(1'b1, 16'h2000 + 16'(k * 16), 1'b0, 64'h0);
      expect_acc(1'b0, 16'h1000 + 16'(k * 16), 1'b0, 64'h0);
    end
    drain(200);
    check_cnts("alt", 5, 6, 7);

    // MEM_LATENCY=1 build: lone D read
    bus_b.d_addr = 16'h0500;
    bus_b.d_req  = 1'b1;
    @(negedge clk);
    check_eq("l1_busy", 64'({bus_b.d_grant, bus_b.readM, bus_b.writeM, bus_b.d_done}),
             64'b1100);
    check_eq("l1_addressM", 64'(bus_b.addressM), 64'h0500);
    @(negedge clk);
    check_eq("l1_done", 64'({bus_b.d_grant, bus_b.readM, bus_b.d_done}), 64'b101);
    check_eq("l1_rdata", bus_b.rdata, mem_line(16'h0500));
    bus_b.d_req = 1'b0;
    @(negedge clk);
    check_eq("l1_idle", 64'({bus_b.d_grant, bus_b.d_done}), 64'h0);
    check_eq("l1_d_grantCnt", 64'(bus_b.d_grantCnt), 64'h1);

    // Reset in the second BUSY cycle aborts the access with no done pulse
    push_i(16'h0300);
    seen = 1'b0;
    for (int n = 0; (n < 20) && !seen; n++) begin
      tick();
      seen = bus_a.i_grant;
    end
    check_eq("abort_grant_seen", 64'(seen), 64'h1);
    tick();
    check_eq("abort_busy2", 64'(bus_a.readM), 64'h1);
    reset = 1'b1;
    i_q.delete();
    drive_reqs();
    tick();
    check_idle("abort");
    tick();
    reset = 1'b0;
    repeat (Lat + 3) tick();
    check_idle("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
